// File: rtl/ps2_kbd_ascii_if.sv
// CPU-facing keyboard port: level interrupt with ASCII head byte and an edge-sensitive ack.
interface ps2_kbd_ascii_if;
  logic       kbd_int;
  logic [7:0] kbd_data;
  logic       kbd_int_ack;

  modport master (
    output kbd_int,
    output kbd_data,
    input  kbd_int_ack
  );

  modport slave (
    input  kbd_int,
    input  kbd_data,
    output kbd_int_ack
  );
endinterface

// File: rtl/ps2_kbd_ascii.sv
// PS/2 set-2 keyboard receiver: frame capture, make/break/shift decode to ASCII, and a small
// FIFO presented to the CPU as a level interrupt.
module ps2_kbd_ascii #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic            clk50M,
  input  logic            rst,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  ps2_kbd_ascii_if.master kbd,
  output logic            frame_err,
  output logic            overflow
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES);
  localparam logic [AddrW:0]  CountFull = (AddrW + 1)'(FIFO_DEPTH);
  localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;
  logic w_fall, w_data;

  state_e          r_state, w_state_d;
  logic [9:0]      r_shreg;
  logic [3:0]      r_bitcnt;
  logic [TmoW-1:0] r_tmo;
  logic            w_tmo_hit, w_frame_ok, w_frame_bad;

  logic [7:0] r_byte;
  logic       r_byte_vld;
  logic       r_shift, r_brk, r_ext;
  logic [8:0] w_map;
  logic       w_prefix, w_shift_key, w_push;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AddrW-1:0] r_wr, r_rd;
  logic [AddrW:0]   r_count;
  logic             r_ack_q, r_kbd_int;
  logic [7:0]       r_kbd_data;
  logic             w_full, w_pop, w_wr_en;

  // Two-flop synchronisers; the third clock flop only serves the falling-edge detector.
  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_s3 & ~r_clk_s2;
  assign w_data = r_dat_s2;

  always_ff @(posedge clk50M) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_fall && !w_data) w_state_d = StShift;
      StShift: begin
        if (w_fall && r_bitcnt == 4'd9) w_state_d = StCheck;
        else if (w_tmo_hit)             w_state_d = StIdle;
      end
      StCheck: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_tmo_hit   = (r_state == StShift) && !w_fall && (r_tmo == TmoLast);
    w_frame_ok  = (r_state == StCheck) && (^r_shreg[8:0]) && r_shreg[9];
    w_frame_bad = (r_state == StCheck) && !w_frame_ok;
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_tmo      <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_byte_vld <= w_frame_ok;
      frame_err  <= w_frame_bad | w_tmo_hit;
      if (w_frame_ok) r_byte <= r_shreg[7:0];
      if (r_state == StShift) begin
        if (w_fall) begin
          r_shreg  <= {w_data, r_shreg[9:1]};
          r_bitcnt <= r_bitcnt + 4'd1;
          r_tmo    <= '0;
        end else begin
          r_tmo <= r_tmo + TmoW'(1);
        end
      end else begin
        r_bitcnt <= '0;
        r_tmo    <= '0;
      end
    end
  end

  function automatic logic [8:0] f_map(input logic [7:0] code, input logic shift);
    logic [4:0] idx;
    logic       letter;
    logic [8:0] res;
    idx    = 5'd0;
    letter = 1'b1;
    res    = 9'h000;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      res = {1'b1, (shift ? 8'h41 : 8'h61) + {3'b000, idx}};
    end else begin
      case (code)
        8'h45: res = {1'b1, 8'h30};  8'h16: res = {1'b1, 8'h31};
        8'h1E: res = {1'b1, 8'h32};  8'h26: res = {1'b1, 8'h33};
        8'h25: res = {1'b1, 8'h34};  8'h2E: res = {1'b1, 8'h35};
        8'h36: res = {1'b1, 8'h36};  8'h3D: res = {1'b1, 8'h37};
        8'h3E: res = {1'b1, 8'h38};  8'h46: res = {1'b1, 8'h39};
        8'h29: res = {1'b1, 8'h20};  8'h5A: res = {1'b1, 8'h0D};
        8'h66: res = {1'b1, 8'h08};  8'h76: res = {1'b1, 8'h1B};
        default: res = 9'h000;
      endcase
    end
    return res;
  endfunction

  assign w_map       = f_map(r_byte, r_shift);
  assign w_prefix    = (r_byte == 8'hE0) || (r_byte == 8'hF0);
  assign w_shift_key = (r_byte == 8'h12) || (r_byte == 8'h59);
  assign w_push      = r_byte_vld && !w_prefix && !w_shift_key && !r_brk && !r_ext && w_map[8];

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_shift <= 1'b0;
      r_brk   <= 1'b0;
      r_ext   <= 1'b0;
    end else if (r_byte_vld) begin
      if (r_byte == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_byte == 8'hF0) begin
        r_brk <= 1'b1;
      end else if (w_shift_key) begin
        r_shift <= ~r_brk;
        r_brk   <= 1'b0;
        r_ext   <= 1'b0;
      end else begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end
    end
  end

  // A simultaneous pop frees a slot, so a push into a full FIFO still succeeds then.
  assign w_full  = (r_count == CountFull);
  assign w_pop   = kbd.kbd_int_ack && !r_ack_q && (r_count != '0);
  assign w_wr_en = w_push && (!w_full || w_pop);

  always_ff @(posedge clk50M) begin
    if (w_wr_en) r_mem[r_wr] <= w_map[7:0];
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_count    <= '0;
      r_ack_q    <= 1'b0;
      r_kbd_int  <= 1'b0;
      r_kbd_data <= 8'h00;
      overflow   <= 1'b0;
    end else begin
      r_ack_q    <= kbd.kbd_int_ack;
      overflow   <= w_push && w_full && !w_pop;
      r_kbd_int  <= (r_count != '0);
      r_kbd_data <= (r_count != '0) ? r_mem[r_rd] : 8'h00;
      if (w_wr_en) r_wr <= r_wr + AddrW'(1);
      if (w_pop)   r_rd <= r_rd + AddrW'(1);
      if (w_wr_en && !w_pop)      r_count <= r_count + (AddrW + 1)'(1);
      else if (w_pop && !w_wr_en) r_count <= r_count - (AddrW + 1)'(1);
    end
  end

  assign kbd.kbd_int  = r_kbd_int;
  assign kbd.kbd_data = r_kbd_data;

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Directed PS/2 frames with a scoreboard of expected ASCII; a negedge monitor checks each pop.
module tb_ps2_kbd_ascii;

  localparam int H = 8;

  logic clk50M = 1'b0;
  logic rst    = 1'b1;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic frame_err, overflow;

  ps2_kbd_ascii_if kbd_if ();

  ps2_kbd_ascii dut (
    .clk50M    (clk50M),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kbd       (kbd_if),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #10 clk50M = ~clk50M;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_err  = 0;
  int n_ovf  = 0;
  int t_fall = 0;
  int t_rise = -1;
  logic [7:0] exp_q [$];
  bit prev_ack = 1'b0;
  bit prev_int = 1'b0;

  always @(posedge clk50M) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a new ack while kbd_int is high consumes the head entry.
  always @(negedge clk50M) begin
    logic [7:0] e;
    if (!rst) begin
      if (frame_err) n_err++;
      if (overflow)  n_ovf++;
      if (kbd_if.kbd_int && !prev_int && t_rise < 0) t_rise = cyc;
      if (kbd_if.kbd_int_ack && !prev_ack && kbd_if.kbd_int) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'(kbd_if.kbd_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", 32'(kbd_if.kbd_data), 32'(e));
        end
      end
    end
    prev_ack = kbd_if.kbd_int_ack;
    prev_int = kbd_if.kbd_int;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk50M);
      #2;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit coinc);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = fr[i];
      tick(H);
      ps2_clk = 1'b0;
      if (i == 10) begin
        t_fall = cyc;
        if (coinc) begin
          tick(4);
          kbd_if.kbd_int_ack = 1'b1;
          tick(H - 4);
        end else begin
          tick(H);
        end
      end else begin
        tick(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(20);
    kbd_if.kbd_int_ack = 1'b0;
    tick(2);
  endtask

  task automatic send(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0);
  endtask

  task automatic send_exp(input logic [7:0] b, input logic [7:0] a);
    exp_q.push_back(a);
    send(b);
  endtask

  task automatic ack_pulse();
    kbd_if.kbd_int_ack = 1'b1;
    tick(1);
    kbd_if.kbd_int_ack = 1'b0;
    tick(3);
  endtask

  initial begin
    logic [7:0] partial;
    kbd_if.kbd_int_ack = 1'b0;
    tick(5);
    chk("rst_kbd_int", 32'(kbd_if.kbd_int), 32'd0);
    chk("rst_kbd_data", 32'(kbd_if.kbd_data), 32'h00);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    tick(5);

    // Single make code and latency from the final clock edge.
    send_exp(8'h1C, 8'h61);
    chk("t1_int", 32'(kbd_if.kbd_int), 32'd1);
    chk("t1_latency_le6", 32'(t_rise >= t_fall && (t_rise - t_fall) <= 6), 32'd1);
    ack_pulse();
    chk("t1_empty", 32'(kbd_if.kbd_int), 32'd0);

    // Shift press, 'A', release a, release shift, 'a'.
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h61);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h1C);
    kbd_if.kbd_int_ack = 1'b1;
    tick(10);
    kbd_if.kbd_int_ack = 1'b0;
    tick(2);
    chk("t2_one_left", 32'(kbd_if.kbd_int), 32'd1);
    chk("t2_q_one_left", 32'(exp_q.size()), 32'd1);
    ack_pulse();
    chk("t2_empty", 32'(kbd_if.kbd_int), 32'd0);

    // Parity error, then a good digit.
    send_byte(8'h1C, 1'b1, 1'b0);
    chk("t3_err_cnt", 32'(n_err), 32'd1);
    chk("t3_no_data", 32'(kbd_if.kbd_int), 32'd0);
    send_exp(8'h45, 8'h30);
    ack_pulse();
    chk("t3_empty", 32'(kbd_if.kbd_int), 32'd0);

    // Partial frame aborted by timeout, then space.
    partial = 8'h29;
    for (int i = 0; i < 4; i++) begin
      ps2_data = (i == 0) ? 1'b0 : partial[i - 1];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(49000);
    chk("t4_no_early_err", 32'(n_err), 32'd1);
    tick(1100);
    chk("t4_timeout_err", 32'(n_err), 32'd2);
    send_exp(8'h29, 8'h20);
    ack_pulse();
    chk("t4_empty", 32'(kbd_if.kbd_int), 32'd0);

    // Fill past capacity, then push and pop on the same cycle.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back(8'h61);
      send(8'h1C);
    end
    chk("t5_ovf_cnt", 32'(n_ovf), 32'd1);
    chk("t5_full_int", 32'(kbd_if.kbd_int), 32'd1);
    exp_q.push_back(8'h61);
    send_byte(8'h1C, 1'b0, 1'b1);
    chk("t5_coinc_no_ovf", 32'(n_ovf), 32'd1);
    chk("t5_q_after_coinc", 32'(exp_q.size()), 32'd8);
    for (int i = 0; i < 7; i++) ack_pulse();
    chk("t5_last_left", 32'(kbd_if.kbd_int), 32'd1);
    ack_pulse();
    chk("t5_drained", 32'(kbd_if.kbd_int), 32'd0);

    // Extended make and break produce nothing; Enter decodes afterwards.
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t6_no_output", 32'(kbd_if.kbd_int), 32'd0);
    chk("t6_no_err", 32'(n_err), 32'd2);
    send_exp(8'h5A, 8'h0D);
    ack_pulse();
    chk("t6_empty", 32'(kbd_if.kbd_int), 32'd0);

    chk("end_q_empty", 32'(exp_q.size()), 32'd0);
    chk("end_ovf_cnt", 32'(n_ovf), 32'd1);
    chk("end_err_cnt", 32'(n_err), 32'd2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
